ppu_sprite_sched: RTL
=====================

Name: ppu_sprite_sched

Overview:
- Frame-coherent write scheduler placed in front of the PPU sprite display modules (Mario, Goomba, Block, Coin, Mush, Ground, Tube, Cloud). Today those modules take the bus writedata directly.
- The block queues host Avalon writes during active video and releases them only during vertical blanking. Each released write is a one-hot per-layer strobe, so no sprite moves mid-frame.
- Only writes queued before vblank starts are released in that vblank. Writes that arrive during vblank wait for the next frame.

Parameters:
- NUM_SPRITES, 20, number of priority layers / write strobes (layer index = compositor priority slot).
- DEPTH, 16, FIFO entries (power of two).
- V_ACTIVE, 480, first vcount value that is vertical blanking.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- writedata  in  32  Avalon write data; [31:27] = target layer id, [26:0] = sprite payload
- write  in  1  Avalon write strobe
- chipselect  in  1  Avalon select
- address  in  3  0 = enqueue sprite write, 1 = clear status flags, others ignored
- hcount  in  10  VGA horizontal count (unused except for bench visibility)
- vcount  in  10  VGA vertical count
- sprite_we  out  NUM_SPRITES  one-hot write strobe to the layer's display module
- sprite_wdata  out  32  full write word presented with sprite_we
- fifo_count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: an enqueue was dropped because the FIFO was full
- bad_id  out  1  sticky: an enqueue was dropped because id >= NUM_SPRITES
- frame_count  out  16  increments at each vblank start, wraps at 65535 -> 0

Behaviour:
- Reset (synchronous): FIFO empty, state WAIT_VBLANK, budget=0, vblank_d=0. All outputs are 0.
- vblank = (vcount >= V_ACTIVE). vblank_d is vblank registered. The vblank_start pulse is vblank & ~vblank_d.
- Enqueue when write & chipselect & address==0:
  - If id >= NUM_SPRITES: drop and set bad_id.
  - Else if the registered fifo_count == DEPTH: drop and set overflow. This holds even if a pop happens in the same cycle.
  - Else push writedata.
- Clear when write & chipselect & address==1: overflow and bad_id go to 0 next cycle. A set event in the same cycle wins, and the flag stays 1.
- States:
  - WAIT_VBLANK: no pops. On vblank_start: budget <= fifo_count, frame_count++, go to DRAIN.
  - DRAIN: when budget>0 and not empty, pop one entry per cycle and decrement budget.
    - When budget==0, go to HOLD.
    - If vblank deasserts while in DRAIN, go to WAIT_VBLANK. The remaining entries are kept and the budget is discarded.
  - HOLD: no pops. When vblank deasserts, go to WAIT_VBLANK.
- Pop-to-strobe latency is 1 cycle. In the cycle after a pop:
  - sprite_we[id] = 1 for exactly one cycle;
  - sprite_wdata = the popped word;
  - when not strobing, sprite_we = 0 and sprite_wdata holds its last value.
- A push and a pop in the same cycle are both honored and fifo_count is unchanged.
- Output order is the FIFO order. There is no coalescing of writes to the same layer.
- At most DEPTH strobes occur per vblank, and never more than the budget snapshot.
- vblank_start while in DRAIN or HOLD is impossible by construction, because vblank must first deassert.
- Reset mid-DRAIN: the queue is flushed, strobes stop the next cycle, and no partial strobe is issued.
- Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.

Decomposition:
- Package ppu_sched_pkg holds:
  - state enum (WAIT_VBLANK, DRAIN, HOLD);
  - address constants ADDR_ENQ=0, ADDR_CLR=1;
  - field constants ID_MSB=31, ID_LSB=27;
  - V_ACTIVE default.
- Sub-module sprite_wr_fifo: synchronous FIFO, 32-bit wide, DEPTH deep, push/pop/count, with a registered read data output. The scheduler FSM and the one-hot decode stay in ppu_sprite_sched.

Test Plan:
- Reset, then vcount=100 and enqueue id=3 word 0x18001234 -> no strobe while vcount<480. At vcount=480, sprite_we[3]=1 for one cycle with sprite_wdata=0x18001234; frame_count=1.
- Enqueue ids 5, 7, 9 during active video -> the vblank yields strobes on bits 5, 7, 9 in consecutive cycles, in that order; fifo_count goes 3 -> 0.
- Enqueue 2 writes before vblank_start and 2 during vblank -> only the first 2 strobe in this vblank; fifo_count=2 in HOLD; the other 2 strobe at the next vblank_start; frame_count=2.
- Enqueue 17 writes with DEPTH=16 -> the 17th is dropped, overflow=1, fifo_count=16. Write address 1 -> overflow=0.
- Enqueue id=25 -> dropped, bad_id=1, fifo_count unchanged.
- Assert reset mid-DRAIN after 2 of 6 strobes -> sprite_we=0 from the cycle after reset; fifo_count=0; no further strobes at the next vblank.

Source files
------------

// File: rtl/ppu_sched_pkg.sv
// Shared types and constants for the frame-coherent sprite write scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ppu_sched_pkg;

  typedef enum logic [1:0] {
    WAIT_VBLANK = 2'd0,
    DRAIN       = 2'd1,
    HOLD        = 2'd2
  } sched_state_t;

  localparam logic [2:0] ADDR_ENQ = 3'd0;
  localparam logic [2:0] ADDR_CLR = 3'd1;

  // Target layer id lives in the top bits of the Avalon write word.
  localparam int ID_MSB = 31;
  localparam int ID_LSB = 27;
  localparam int ID_W   = ID_MSB - ID_LSB + 1;

  localparam int V_ACTIVE_DEFAULT = 480;

endpackage

// File: rtl/sprite_wr_fifo.sv
// Synchronous FIFO holding queued sprite writes; pop_data is registered.
// Latency: pop at edge N presents the word on pop_data after edge N; push visible in count after edge.
// Backpressure: none internally; caller must not push when full or pop when empty.
// Ports: clk/reset (sync, active-high), push/push_data, pop/pop_data, count (0..DEPTH), empty, full.
module sprite_wr_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      pop_data <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr     <= rptr + AW'(1);
        pop_data <= mem[rptr];
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/ppu_sprite_sched.sv
// Queues host sprite writes during active video and releases them as one-hot layer strobes in vblank.
// Latency: pop-to-strobe 1 cycle; first strobe 2 cycles after vcount reaches V_ACTIVE.
// Backpressure: none to host; writes are dropped (sticky overflow/bad_id) when full or id invalid.
// Ports: Avalon slave (writedata/write/chipselect/address), VGA counters (hcount/vcount),
//        sprite_we/sprite_wdata to display modules, fifo_count/overflow/bad_id/frame_count status.
module ppu_sprite_sched
  import ppu_sched_pkg::*;
#(
  parameter int NUM_SPRITES = 20,
  parameter int DEPTH       = 16,
  parameter int V_ACTIVE    = V_ACTIVE_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              writedata,
  input  logic                     write,
  input  logic                     chipselect,
  input  logic [2:0]               address,
  input  logic [9:0]               hcount,
  input  logic [9:0]               vcount,
  output logic [NUM_SPRITES-1:0]   sprite_we,
  output logic [31:0]              sprite_wdata,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     bad_id,
  output logic [15:0]              frame_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  sched_state_t     state, state_nxt;
  logic [CW-1:0]    budget;
  logic             vblank, vblank_d, vblank_start;
  logic             enq, clr, id_ok, push, pop, pop_q;
  logic             fifo_empty, fifo_full;
  logic [31:0]      fifo_rd;
  logic [ID_W-1:0]  wr_id, rd_id;
  logic             unused_hcount;

  // hcount is carried on the port for debug visibility only.
  assign unused_hcount = ^hcount;

  assign vblank       = (vcount >= 10'(V_ACTIVE));
  assign vblank_start = vblank & ~vblank_d;

  assign enq   = write & chipselect & (address == ADDR_ENQ);
  assign clr   = write & chipselect & (address == ADDR_CLR);
  assign wr_id = writedata[ID_MSB:ID_LSB];
  assign id_ok = (32'(wr_id) < 32'(NUM_SPRITES));
  // Full is judged on the registered count, so a same-cycle pop does not make room.
  assign push  = enq & id_ok & ~fifo_full;

  sprite_wr_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (writedata),
    .pop       (pop),
    .pop_data  (fifo_rd),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_VBLANK;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      WAIT_VBLANK: begin
        if (vblank_start) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Leaving vblank early abandons the budget; queued words wait for next frame.
        if (!vblank) begin
          state_nxt = WAIT_VBLANK;
        end else if (budget == '0) begin
          state_nxt = HOLD;
        end else if (!fifo_empty) begin
          pop = 1'b1;
        end
      end
      HOLD: begin
        if (!vblank) state_nxt = WAIT_VBLANK;
      end
      default: state_nxt = WAIT_VBLANK;
    endcase
  end

  // Budget snapshots occupancy at vblank start, so writes landing during vblank are deferred.
  always_ff @(posedge clk) begin
    if (reset) begin
      budget      <= '0;
      vblank_d    <= 1'b0;
      frame_count <= '0;
      pop_q       <= 1'b0;
    end else begin
      vblank_d <= vblank;
      pop_q    <= pop;
      if (state == WAIT_VBLANK && vblank_start) begin
        budget <= fifo_count;
      end else if (pop) begin
        budget <= budget - CW'(1);
      end
      if (vblank_start) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  // Set beats clear when both occur in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      bad_id   <= 1'b0;
    end else begin
      if (enq && !id_ok) begin
        bad_id <= 1'b1;
      end else if (clr) begin
        bad_id <= 1'b0;
      end
      if (enq && id_ok && fifo_full) begin
        overflow <= 1'b1;
      end else if (clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Strobe follows the registered FIFO read word; wdata holds between strobes.
  assign rd_id        = fifo_rd[ID_MSB:ID_LSB];
  assign sprite_wdata = fifo_rd;

  always_comb begin
    sprite_we = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      sprite_we[i] = pop_q && (rd_id == ID_W'(i));
    end
  end

endmodule
